mem_stage_ctrl: RTL and testbench

// - Consumer end of the EX/MEM pipeline interface. Reads the EX/MEM bundle and issues the access to the multi-cycle data memory.
// - Holds the pipeline (stall_out, which drives EX/MEM en low) until the memory completes.
// - Delivers a registered, valid-qualified bundle to the MEM/WB latch.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/mem_wait_counter.sv | 29 ++
 rtl/mem_stage_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: state encodings and default datapath widths
// for the MEM-stage controller.
package pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_ERR  = ST_ERR
  } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Saturating wait-cycle counter for the MEM stage; at_limit flags that the
// outstanding access has used up its MAX_WAIT cycle budget.
module mem_wait_counter #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] count;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     count <= 8'd0;
    else if (clr) count <= 8'd0;
    else if (inc) count <= sat_inc(count);
  end

  assign at_limit = (count >= LIMIT);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues EX/MEM accesses to a multi-cycle data memory,
// stalls upstream until completion and registers the MEM/WB bundle.
// Optional build macro: MEM_ALIGN_CHECK_EN (trap odd addresses on memory ops).
module mem_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_dmem_en,
  input  logic              ex_dmem_wr,
  input  logic              ex_dump,
  input  logic [REG_AW-1:0] ex_writereg,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_dump,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              stall_out,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] wb_writereg,
  output logic [DATA_W-1:0] wb_alu,
  output logic [DATA_W-1:0] wb_memdata,
  output logic              err
);

  state_t state;

  logic              idle;
  logic              in_wait;
  logic              mem_op;
  logic              misalign;
  logic              issue;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              at_limit;

  logic              hold_regwrite_p1;
  logic              hold_memtoreg_p1;
  logic              hold_wr_p1;
  logic [REG_AW-1:0] hold_writereg_p1;
  logic [DATA_W-1:0] hold_alu_p1;
  logic [DATA_W-1:0] hold_b_p1;

  assign idle    = (state == S_IDLE);
  assign in_wait = (state == S_WAIT);

  // A dump is a halt marker, never a memory access, even if dmem_en is set.
  assign mem_op = ex_valid & ex_dmem_en & ~ex_dump;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & ex_alu[0];
`else
  assign misalign = 1'b0;
`endif

  assign issue = idle & mem_op & ~misalign;

  assign mem_rd    = issue & ~ex_dmem_wr;
  assign mem_wr    = issue & ex_dmem_wr;
  assign mem_dump  = idle & ex_valid & ex_dump;
  assign mem_addr  = idle ? ex_alu : hold_alu_p1;
  assign mem_wdata = idle ? ex_b   : hold_b_p1;

  always_comb begin
    stall_out = 1'b1;
    case (state)
      S_IDLE:  stall_out = misalign | (issue & ~mem_done);
      S_WAIT:  stall_out = ~mem_done;
      default: stall_out = 1'b1;
    endcase
  end

  assign cnt_inc = (issue | in_wait) & ~mem_done;
  assign cnt_clr = ~cnt_inc;

  mem_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .at_limit (at_limit)
  );

  // Stage p1: bundle parked while the memory is busy
  always_ff @(posedge clk) begin
    if (issue) begin
      hold_regwrite_p1 <= ex_regwrite;
      hold_memtoreg_p1 <= ex_memtoreg;
      hold_wr_p1       <= ex_dmem_wr;
      hold_writereg_p1 <= ex_writereg;
      hold_alu_p1      <= ex_alu;
      hold_b_p1        <= ex_b;
    end
  end

  // Stage wb: FSM and registered MEM/WB bundle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      err         <= 1'b0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_writereg <= '0;
      wb_alu      <= '0;
      wb_memdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wb_valid <= 1'b0;
          if (misalign) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else if (mem_op) begin
            if (mem_done) begin
              wb_valid    <= 1'b1;
              wb_regwrite <= ex_regwrite;
              wb_memtoreg <= ex_memtoreg;
              wb_writereg <= ex_writereg;
              wb_alu      <= ex_alu;
              wb_memdata  <= ex_dmem_wr ? '0 : mem_rdata;
            end else begin
              state <= S_WAIT;
            end
          end else if (ex_valid) begin
            wb_valid    <= 1'b1;
            wb_regwrite <= ex_regwrite;
            wb_memtoreg <= ex_memtoreg;
            wb_writereg <= ex_writereg;
            wb_alu      <= ex_alu;
            wb_memdata  <= '0;
          end
        end
        S_WAIT: begin
          wb_valid <= 1'b0;
          if (mem_done) begin
            state       <= S_IDLE;
            wb_valid    <= 1'b1;
            wb_regwrite <= hold_regwrite_p1;
            wb_memtoreg <= hold_memtoreg_p1;
            wb_writereg <= hold_writereg_p1;
            wb_alu      <= hold_alu_p1;
            wb_memdata  <= hold_wr_p1 ? '0 : mem_rdata;
          end else if (at_limit) begin
            state <= S_ERR;
            err   <= 1'b1;
          end
        end
        S_ERR: begin
          wb_valid <= 1'b0;
          err      <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table of single-cycle ops,
// scoreboard on the MEM/WB bundle, and hand sequences for multi-cycle cases.
module tb_mem_stage_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_regwrite, ex_memtoreg, ex_dmem_en, ex_dmem_wr, ex_dump;
  logic [AW-1:0] ex_writereg;
  logic [DW-1:0] ex_alu, ex_b;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_rd, mem_wr, mem_dump, mem_done, stall_out;
  logic          wb_valid, wb_regwrite, wb_memtoreg, err;
  logic [AW-1:0] wb_writereg;
  logic [DW-1:0] wb_alu, wb_memdata;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_W(DW), .REG_AW(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_dmem_en(ex_dmem_en), .ex_dmem_wr(ex_dmem_wr), .ex_dump(ex_dump),
    .ex_writereg(ex_writereg), .ex_alu(ex_alu), .ex_b(ex_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dump(mem_dump), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_out(stall_out), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_writereg(wb_writereg), .wb_alu(wb_alu),
    .wb_memdata(wb_memdata), .err(err)
  );

  typedef struct {
    logic          regwrite;
    logic          memtoreg;
    logic [AW-1:0] writereg;
    logic [DW-1:0] alu;
    logic [DW-1:0] memdata;
  } wb_t;

  typedef struct {
    logic          valid, regwrite, memtoreg, en, wr, dump;
    logic [AW-1:0] writereg;
    logic [DW-1:0] alu, b;
    logic          done;
    logic [DW-1:0] rdata;
    logic          exp_rd, exp_wr, exp_dump, exp_wbv;
    logic [DW-1:0] exp_memdata;
  } vec_t;

  wb_t  sb[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic m2r, input logic en,
                        input logic wr, input logic dmp, input logic [AW-1:0] wreg,
                        input logic [DW-1:0] alu, input logic [DW-1:0] b);
    ex_valid = v; ex_regwrite = rw; ex_memtoreg = m2r; ex_dmem_en = en;
    ex_dmem_wr = wr; ex_dump = dmp; ex_writereg = wreg; ex_alu = alu; ex_b = b;
  endtask

  task automatic drive_idle();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    mem_done  = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic push(input logic rw, input logic m2r, input logic [AW-1:0] wreg,
                      input logic [DW-1:0] alu, input logic [DW-1:0] md);
    wb_t e;
    e.regwrite = rw; e.memtoreg = m2r; e.writereg = wreg; e.alu = alu; e.memdata = md;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    #1;
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    next_cycle();
    rst = 1'b1;
  endtask

  // Scoreboard: every valid MEM/WB bundle must match the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1 && wb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", {31'b0, wb_valid}, 32'd0);
        end else begin
          wb_t e;
          e = sb.pop_front();
          check("sb_regwrite", {31'b0, wb_regwrite}, {31'b0, e.regwrite});
          check("sb_memtoreg", {31'b0, wb_memtoreg}, {31'b0, e.memtoreg});
          check("sb_writereg", {29'b0, wb_writereg}, {29'b0, e.writereg});
          check("sb_alu", {16'b0, wb_alu}, {16'b0, e.alu});
          check("sb_memdata", {16'b0, wb_memdata}, {16'b0, e.memdata});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic run_store(input logic with_done);
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0200, 16'h1357);
    mem_done = 1'b0;
    if (with_done) push(1'b0, 1'b0, 3'd2, 16'h0200, 16'h0000);
    #1;
    check("st_req_wr", {31'b0, mem_wr}, 32'd1);
    check("st_req_stall", {31'b0, stall_out}, 32'd1);
    next_cycle();
    drive_idle();
    for (int k = 1; k <= MW; k++) begin
      if (with_done && k == MW) begin
        mem_done  = 1'b1;
        mem_rdata = 16'hFFFF;
      end
      #1;
      check("st_wait_stall", {31'b0, stall_out}, (with_done && k == MW) ? 32'd0 : 32'd1);
      check("st_wait_err", {31'b0, err}, 32'd0);
      check("st_wait_wr", {31'b0, mem_wr}, 32'd0);
      check("st_wait_addr", {16'b0, mem_addr}, 32'h0200);
      check("st_wait_wdata", {16'b0, mem_wdata}, 32'h1357);
      next_cycle();
    end
    mem_done = 1'b0;
    if (with_done) begin
      check("st_limit_done_wbv", {31'b0, wb_valid}, 32'd1);
      check("st_limit_done_err", {31'b0, err}, 32'd0);
    end else begin
      check("st_timeout_err", {31'b0, err}, 32'd1);
      check("st_timeout_stall", {31'b0, stall_out}, 32'd1);
      check("st_timeout_wbv", {31'b0, wb_valid}, 32'd0);
      set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0400, 16'h0);
      mem_done = 1'b1;
      #1;
      check("err_no_rd", {31'b0, mem_rd}, 32'd0);
      check("err_stall", {31'b0, stall_out}, 32'd1);
      next_cycle();
      check("err_sticky", {31'b0, err}, 32'd1);
      check("err_wbv", {31'b0, wb_valid}, 32'd0);
      drive_idle();
      do_reset();
      check("post_rst_err", {31'b0, err}, 32'd0);
      check("post_rst_wbv", {31'b0, wb_valid}, 32'd0);
      check("post_rst_alu", {16'b0, wb_alu}, 32'd0);
      check("post_rst_stall", {31'b0, stall_out}, 32'd0);
    end
  endtask

  initial begin
    int rd_pulses;
    int stall_cnt;
    vec_t v;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0040, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0042, 16'hCAFE, 1'b1, 16'h7777, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 16'h5555, 16'h0000, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 16'h8000, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 16'h0F0F, 16'h0000, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};

    rst = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #2;
    check("init_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("init_err", {31'b0, err}, 32'd0);
    check("init_wb_alu", {16'b0, wb_alu}, 32'd0);
    check("init_wb_memdata", {16'b0, wb_memdata}, 32'd0);
    check("init_stall", {31'b0, stall_out}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      set_ex(v.valid, v.regwrite, v.memtoreg, v.en, v.wr, v.dump, v.writereg, v.alu, v.b);
      mem_done  = v.done;
      mem_rdata = v.rdata;
      if (v.exp_wbv) push(v.regwrite, v.memtoreg, v.writereg, v.alu, v.exp_memdata);
      #1;
      check("vec_rd", {31'b0, mem_rd}, {31'b0, v.exp_rd});
      check("vec_wr", {31'b0, mem_wr}, {31'b0, v.exp_wr});
      check("vec_dump", {31'b0, mem_dump}, {31'b0, v.exp_dump});
      check("vec_stall", {31'b0, stall_out}, 32'd0);
      if (v.exp_rd || v.exp_wr) check("vec_addr", {16'b0, mem_addr}, {16'b0, v.alu});
      if (v.exp_wr) check("vec_wdata", {16'b0, mem_wdata}, {16'b0, v.b});
      next_cycle();
      check("vec_wbv", {31'b0, wb_valid}, {31'b0, v.exp_wbv});
    end
    drive_idle();

    // Load completing three cycles after the request.
    set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 16'h0100, 16'h0000);
    push(1'b1, 1'b1, 3'd4, 16'h0100, 16'h5A5A);
    rd_pulses = 0;
    stall_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        mem_done  = 1'b1;
        mem_rdata = 16'h5A5A;
      end
      #1;
      rd_pulses += int'(mem_rd);
      stall_cnt += int'(stall_out);
      if (c > 0) check("slow_addr_hold", {16'b0, mem_addr}, 32'h0100);
      next_cycle();
      if (c == 0) set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'hDEAD, 16'h0000);
      if (c < 3) check("slow_wbv_low", {31'b0, wb_valid}, 32'd0);
    end
    check("slow_rd_pulses", rd_pulses, 32'd1);
    check("slow_stall_cycles", stall_cnt, 32'd3);
    check("slow_wbv", {31'b0, wb_valid}, 32'd1);
    drive_idle();
    next_cycle();

    run_store(1'b1);
    drive_idle();
    next_cycle();
    run_store(1'b0);

    // Reset lands while a load is outstanding; the late done must be ignored.
    set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0300, 16'h0000);
    next_cycle();
    drive_idle();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sb.delete();
    #1;
    check("midwait_rst_stall", {31'b0, stall_out}, 32'd0);
    check("midwait_rst_wbv", {31'b0, wb_valid}, 32'd0);
    next_cycle();
    rst = 1'b1;
    mem_done  = 1'b1;
    mem_rdata = 16'hABCD;
    #1;
    check("late_done_rd", {31'b0, mem_rd}, 32'd0);
    check("late_done_stall", {31'b0, stall_out}, 32'd0);
    next_cycle();
    check("late_done_wbv", {31'b0, wb_valid}, 32'd0);
    drive_idle();

    // Odd address on a load.
    set_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0011, 16'h0000);
    mem_done  = 1'b1;
    mem_rdata = 16'h2468;
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    check("align_no_rd", {31'b0, mem_rd}, 32'd0);
    check("align_stall", {31'b0, stall_out}, 32'd1);
    next_cycle();
    check("align_err", {31'b0, err}, 32'd1);
    check("align_wbv", {31'b0, wb_valid}, 32'd0);
    drive_idle();
    do_reset();
`else
    push(1'b1, 1'b1, 3'd1, 16'h0011, 16'h2468);
    #1;
    check("odd_rd", {31'b0, mem_rd}, 32'd1);
    check("odd_addr", {16'b0, mem_addr}, 32'h0011);
    next_cycle();
    check("odd_wbv", {31'b0, wb_valid}, 32'd1);
    check("odd_err", {31'b0, err}, 32'd0);
    drive_idle();
`endif

    next_cycle();
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
